// File: rtl/duc_pkg.sv
// duc_pkg: shared constants, quarter-wave ROM generator and quadrant fold for the up-converter
package duc_pkg;
  localparam int LATENCY = 6;
  localparam int SHIFT = 16 + 14 - 14 - 1;
  localparam int A = 2 ** (14 - 1) - 1;
  typedef struct packed {
    logic neg;
    logic mirror;
  } quad_t;
  // First-quadrant table entry round(a*sin(2*pi*k / 2^(aw+2))); never negative, so +0.5 rounds
  function automatic int lut_entry(int k, int aw, int a);
    return $rtoi(a * $sin(6.283185307179586 * k / (2.0 ** (aw + 2))) + 0.5);
  endfunction
  // Quadrants 1 and 3 read the table backwards, quadrants 2 and 3 are negated
  function automatic quad_t quad_fold(logic [1:0] q);
    return '{neg: q[1], mirror: q[0]};
  endfunction
endpackage

// File: rtl/duc_if.sv
// duc_if: baseband, phase-control and DAC-side signals of the up-converter
interface duc_if #(
  parameter int DATA_W = 16,
  parameter int PHASE_W = 32
);
  logic [2*DATA_W-1:0] bb_in;
  logic valid_in;
  logic [2*PHASE_W-1:0] phase_in;
  logic phase_valid;
  logic resync;
  logic [15:0] dac_out;
  logic valid_out;
  logic [15:0] underrun_cnt;
  modport master (
    output bb_in, valid_in, phase_in, phase_valid, resync,
    input dac_out, valid_out, underrun_cnt
  );
  modport slave (
    input bb_in, valid_in, phase_in, phase_valid, resync,
    output dac_out, valid_out, underrun_cnt
  );
endinterface

// File: rtl/nco_sincos.sv
// nco_sincos: quarter-wave sin/cos NCO, truncated phase in, registered cos/sin out 3 cycles later
module nco_sincos
  import duc_pkg::*;
#(
  parameter int LO_W = 14,
  parameter int LUT_AW = 10
) (
  input logic clk,
  input logic rst_n,
  input logic [LUT_AW+1:0] phase,
  output logic signed [LO_W-1:0] cos_lo,
  output logic signed [LO_W-1:0] sin_lo
);
  localparam int N = 2 ** LUT_AW;
  localparam logic signed [LO_W-1:0] AMP = LO_W'(2 ** (LO_W - 1) - 1);
  logic signed [LO_W-1:0] rom [N];
  logic [LUT_AW-1:0] k;
  logic [1:0] qc;
  quad_t fs, fc;
  logic [LUT_AW-1:0] addr_s, addr_c;
  logic full_s, full_c, neg2_s, neg2_c, neg3_s, neg3_c;
  logic signed [LO_W-1:0] mag_s, mag_c;
  for (genvar g = 0; g < N; g++) begin : g_rom
    assign rom[g] = LO_W'(lut_entry(g, LUT_AW, 2 ** (LO_W - 1) - 1));
  end
  assign k = phase[LUT_AW-1:0];
  assign qc = phase[LUT_AW+1:LUT_AW] + 2'd1;
  assign fs = quad_fold(phase[LUT_AW+1:LUT_AW]);
  assign fc = quad_fold(qc);
  // Fold sin phase and the quarter-turn-advanced cos phase into table address plus sign;
  // a mirrored read at k=0 lands one past the table and means full amplitude
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_s <= '0;
      addr_c <= '0;
      full_s <= 1'b0;
      full_c <= 1'b0;
      neg2_s <= 1'b0;
      neg2_c <= 1'b0;
    end else begin
      addr_s <= fs.mirror ? -k : k;
      addr_c <= fc.mirror ? -k : k;
      full_s <= fs.mirror && k == '0;
      full_c <= fc.mirror && k == '0;
      neg2_s <= fs.neg;
      neg2_c <= fc.neg;
    end
  // Single ROM read twice per cycle for the two magnitudes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mag_s <= '0;
      mag_c <= '0;
      neg3_s <= 1'b0;
      neg3_c <= 1'b0;
    end else begin
      mag_s <= full_s ? AMP : rom[addr_s];
      mag_c <= full_c ? AMP : rom[addr_c];
      neg3_s <= neg2_s;
      neg3_c <= neg2_c;
    end
  // Apply quadrant sign
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sin_lo <= '0;
      cos_lo <= '0;
    end else begin
      sin_lo <= neg3_s ? -mag_s : mag_s;
      cos_lo <= neg3_c ? -mag_c : mag_c;
    end
endmodule

// File: rtl/duc_core.sv
// duc_core: DAQ2 transmit up-converter, dac = sat(round(I*cos - Q*sin)) from an internal NCO
module duc_core
  import duc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LO_W = 14,
  parameter int PHASE_W = 32,
  parameter int LUT_AW = 10,
  parameter int OUT_W = 14
) (
  input logic clk,
  input logic rst_n,
  duc_if.slave bus
);
  localparam int PW = DATA_W + LO_W;
  localparam int SH = DATA_W + LO_W - OUT_W - 1;
  localparam int RW = PW + 1 - SH;
  localparam logic signed [PW:0] HALF = (PW + 1)'(1) << (SH - 1);
  localparam logic signed [RW-1:0] MAXV = RW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (OUT_W - 1)));
  logic [PHASE_W-1:0] pinc, poff, acc;
  logic p_conf, load0, gate;
  logic [15:0] underrun;
  logic [LUT_AW+1:0] s1_phase;
  logic signed [DATA_W-1:0] s1_i, s1_q;
  logic [2:0][DATA_W-1:0] d_i, d_q;
  logic signed [LO_W-1:0] cos_lo, sin_lo;
  logic signed [PW-1:0] prod_i, prod_q;
  logic signed [PW:0] diff;
  logic signed [RW-1:0] rnd;
  logic signed [OUT_W-1:0] sat;
  logic [LATENCY-1:0] vld;
  logic [15:0] dac;
  assign load0 = bus.phase_valid & bus.resync;
  assign gate = p_conf & bus.valid_in;
  // Phase control: pinc/poff load on phase_valid while acc still advances by the old pinc
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pinc <= '0;
      poff <= '0;
      p_conf <= 1'b0;
      acc <= '0;
    end else begin
      if (bus.phase_valid) begin
        pinc <= bus.phase_in[PHASE_W-1:0];
        poff <= bus.phase_in[2*PHASE_W-1:PHASE_W];
        p_conf <= 1'b1;
      end
      acc <= load0 ? '0 : p_conf ? acc + pinc : '0;
    end
  // Saturating count of configured cycles that had no baseband sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) underrun <= '0;
    else underrun <= load0 ? '0 : (p_conf && !bus.valid_in && underrun != '1) ? underrun + 16'd1 : underrun;
  // Stage 1: truncated phase and gated baseband (zeros injected on underrun)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_phase <= '0;
      s1_i <= '0;
      s1_q <= '0;
    end else begin
      s1_phase <= (LUT_AW + 2)'((acc + poff) >> (PHASE_W - LUT_AW - 2));
      s1_i <= gate ? bus.bb_in[DATA_W-1:0] : '0;
      s1_q <= gate ? bus.bb_in[2*DATA_W-1:DATA_W] : '0;
    end
  nco_sincos #(.LO_W(LO_W), .LUT_AW(LUT_AW)) u_nco (
    .clk(clk),
    .rst_n(rst_n),
    .phase(s1_phase),
    .cos_lo(cos_lo),
    .sin_lo(sin_lo)
  );
  // Baseband rides alongside the NCO stages; valid tracks p_conf through the whole pipe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_i <= '0;
      d_q <= '0;
      vld <= '0;
    end else begin
      d_i <= {d_i[1:0], s1_i};
      d_q <= {d_q[1:0], s1_q};
      vld <= {vld[LATENCY-2:0], p_conf};
    end
  // Stage 5: mix
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prod_i <= '0;
      prod_q <= '0;
    end else begin
      prod_i <= $signed(d_i[2]) * cos_lo;
      prod_q <= $signed(d_q[2]) * sin_lo;
    end
  // Difference, half-up rounding by arithmetic shift, clamp to the DAC range
  always_comb begin
    diff = (PW + 1)'(prod_i) - (PW + 1)'(prod_q);
    rnd = RW'((diff + HALF) >>> SH);
    sat = rnd > MAXV ? MAXV[OUT_W-1:0] : rnd < MINV ? MINV[OUT_W-1:0] : rnd[OUT_W-1:0];
  end
  // Stage 6: registered DAC word, sign-extended to 16 bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dac <= '0;
    else dac <= 16'(sat);
  assign bus.dac_out = dac;
  assign bus.valid_out = vld[LATENCY-1];
  assign bus.underrun_cnt = underrun;
endmodule

// File: tb/tb_duc_core.sv
// tb_duc_core: directed stimulus with an expected-value queue and a separate output monitor
module tb_duc_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int ph = 0, stp = 0, off = 0, ur = 0;
  bit conf = 1'b0;
  int cs [8] = '{8191, 5792, 0, -5792, -8191, -5792, 0, 5792};
  int sn [8] = '{0, 5792, 8191, 5792, 0, -5792, -8191, -5792};
  duc_if bus ();
  duc_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  // Phase in eighths of a turn; cos/sin tabulated by hand for those angles
  function automatic int expect_val(int i, int q, int o);
    longint d;
    longint r;
    d = longint'(i) * cs[o] - longint'(q) * sn[o];
    r = (d + 16384) >>> 15;
    return r > 8191 ? 8191 : r < -8192 ? -8192 : int'(r);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; pe/oe are pinc/poff in eighths of a turn
  task automatic step(input int i, input int q, input bit v, input bit pv = 1'b0,
                      input bit rs = 1'b0, input int pe = 0, input int oe = 0);
    bus.bb_in = {16'(q), 16'(i)};
    bus.valid_in = v;
    bus.phase_valid = pv;
    bus.resync = rs;
    bus.phase_in = {32'(oe) << 29, 32'(pe) << 29};
    if (conf) exp_q.push_back(expect_val(v ? i : 0, v ? q : 0, (ph + off) % 8));
    ur = (pv && rs) ? 0 : (conf && !v && ur < 65535) ? ur + 1 : ur;
    ph = (pv && rs) ? 0 : conf ? (ph + stp) % 8 : 0;
    if (pv) begin
      stp = pe;
      off = oe;
      conf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("underrun_cnt", int'(bus.underrun_cnt), ur);
    bus.phase_valid = 1'b0;
    bus.resync = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n && bus.valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dac_out: valid_out=1 with no expected sample queued");
      end else check("dac_out", int'($signed(bus.dac_out)), exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.bb_in = '0;
    bus.valid_in = 1'b0;
    bus.phase_in = '0;
    bus.phase_valid = 1'b0;
    bus.resync = 1'b0;
    for (int n = 0; n < 6; n++) begin
      bus.bb_in = $urandom();
      bus.valid_in = 1'($urandom());
      bus.phase_in = {$urandom(), $urandom()};
      bus.phase_valid = 1'($urandom());
      bus.resync = 1'($urandom());
      @(negedge clk);
      check("rst_dac_out", int'(bus.dac_out), 0);
      check("rst_valid_out", int'(bus.valid_out), 0);
      check("rst_underrun", int'(bus.underrun_cnt), 0);
    end
    bus.phase_valid = 1'b0;
    bus.resync = 1'b0;
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step(int'($urandom_range(0, 1000)), 5, n[0]);
      check("unconf_valid_out", int'(bus.valid_out), 0);
      check("unconf_dac_out", int'(bus.dac_out), 0);
    end
    // DC at phase 0: exact half-up rounding case 4096, valid_out rises 7 cycles after phase_valid
    step(0, 0, 1'b1, 1'b1, 1'b1, 0, 0);
    repeat (5) step(16384, 0, 1'b1);
    check("valid_out_before_fill", int'(bus.valid_out), 0);
    step(16384, 0, 1'b1);
    check("valid_out_rise", int'(bus.valid_out), 1);
    repeat (5) step(16384, 0, 1'b1);
    // Quarter-turn tone: 4096, 0, -4095, 0
    step(16384, 0, 1'b1, 1'b1, 1'b1, 2, 0);
    repeat (12) step(16384, 0, 1'b1);
    // New pinc without resync: acc takes one more step with the old pinc
    step(16384, 0, 1'b1, 1'b1, 1'b0, 1, 0);
    repeat (9) step(16384, 0, 1'b1);
    // Saturation at 45 degrees in both directions, then an in-range value
    step(32767, -32768, 1'b1, 1'b1, 1'b1, 0, 1);
    repeat (6) step(32767, -32768, 1'b1);
    repeat (6) step(-32768, 32767, 1'b1);
    repeat (3) step(1000, 0, 1'b1);
    // Underrun: five dropped samples count and become zeros at the output
    step(16384, 0, 1'b1, 1'b1, 1'b1, 2, 0);
    repeat (3) step(16384, 0, 1'b1);
    repeat (5) step(12345, 999, 1'b0);
    check("underrun_after_gap", int'(bus.underrun_cnt), 5);
    repeat (7) step(16384, 0, 1'b1);
    step(16384, 0, 1'b1, 1'b1, 1'b1, 2, 0);
    check("underrun_cleared", int'(bus.underrun_cnt), 0);
    repeat (10) step(16384, 0, 1'b1);
    // Mid-stream reset with a non-zero output and counter
    step(16384, 0, 1'b1, 1'b1, 1'b1, 0, 0);
    repeat (7) step(16384, 0, 1'b1);
    repeat (2) step(0, 0, 1'b0);
    #1;
    check("in_flight_samples", exp_q.size(), 5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dac_out", int'(bus.dac_out), 0);
    check("async_rst_valid_out", int'(bus.valid_out), 0);
    check("async_rst_underrun", int'(bus.underrun_cnt), 0);
    exp_q.delete();
    conf = 1'b0;
    ph = 0;
    stp = 0;
    off = 0;
    ur = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step(16384, 0, 1'b1);
      check("post_rst_valid_out", int'(bus.valid_out), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/duc_core.md
# duc_core

Digital up-converter for the DAQ2 transmit path, the mirror of the receive-side down-converter. It takes complex baseband I/Q samples, mixes them with an internal NCO, and produces one real, saturated sample per clock for the DAC: `out = I·cos − Q·sin`. Phase increment, phase offset and resync use the same phase-word convention as the receive side, so a tone programmed on both paths stays phase-coherent.

## Interface
Parameters:
- DATA_W, 16: signed width of baseband I and Q.
- LO_W, 14: signed width of NCO cos/sin; amplitude A = 2^(LO_W−1)−1.
- PHASE_W, 32: accumulator width.
- LUT_AW, 10: quarter-wave LUT address width.
- OUT_W, 14: signed DAC sample width.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- bb_in, input, 2·DATA_W: [2·DATA_W−1:DATA_W] Q, [DATA_W−1:0] I, both two's complement.
- valid_in, input, 1: qualifies bb_in.
- phase_in, input, 2·PHASE_W: [PHASE_W−1:0] pinc, [2·PHASE_W−1:PHASE_W] poff.
- phase_valid, input, 1: loads phase_in.
- resync, input, 1: sampled only when phase_valid=1; clears the accumulator.
- dac_out, output, 16: OUT_W-bit result in [OUT_W−1:0], sign-extended to 16 bits.
- valid_out, output, 1: dac_out is meaningful.
- underrun_cnt, output, 16: saturating count of configured cycles with valid_in=0.

## Operation
- Reset clears pinc, poff, acc, p_conf, all pipeline registers and underrun_cnt. All outputs are 0 during and after reset.
- **Phase load** on phase_valid=1:
  - pinc and poff load on the clock edge; p_conf is set and stays set until reset.
  - If resync=1 on the same cycle, acc loads 0 on that edge. Otherwise acc takes acc+old pinc, and the new pinc applies from the next cycle.
- **Accumulator:** every cycle with p_conf=1 and no resync load, acc ← acc + pinc, wrapping modulo 2^PHASE_W. When p_conf=0, acc holds 0.
- **Phase:** the sample presented at cycle t uses phase φ = (acc(t) + poff) mod 2^PHASE_W. Only the top LUT_AW+2 bits are used (truncation, no dither).
- **NCO:** the top 2 phase bits give the quadrant; the next LUT_AW bits give the address k.
  - LUT[k] = round(A·sin(2πk / 2^(LUT_AW+2))) for k = 0 … 2^LUT_AW − 1.
  - Mirrored quadrants read LUT[2^LUT_AW − k]. A mirrored read with k=0 returns A.
  - Signs are applied per quadrant. cos is derived from the phase plus one quarter turn.
- **Input gating:** while p_conf=1 and valid_in=0, I=Q=0 is injected, the NCO keeps running, and underrun_cnt increments (saturating at 0xFFFF).
  - underrun_cnt clears on phase_valid&resync.
  - Before p_conf is set, underrun_cnt does not count.
- **Arithmetic:**
  - Products I·cos and Q·sin are (DATA_W+LO_W) bits; their difference is DATA_W+LO_W+1 bits.
  - SHIFT = DATA_W+LO_W−OUT_W−1 (15 at defaults).
  - Rounding is half-up: floor((d + 2^(SHIFT−1)) / 2^SHIFT).
  - The result saturates to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- valid_out = p_conf delayed by LATENCY. Every cycle after the pipeline fills is valid, because the DAC stream is continuous.

## Timing
- LATENCY = 6. A sample accepted at cycle t appears on dac_out at t+6.
- Pipeline stages:
  1. Register φ and bb (gated).
  2. Quadrant fold / address.
  3. LUT read.
  4. Sign apply.
  5. Multiply.
  6. Subtract, round, saturate.
- First phase_valid at cycle t0: valid_out rises at t0+1+6, and the first valid output uses φ = poff (with resync) or 0+poff (acc is 0 before config, so resync is irrelevant).
- Reset mid-stream: all outputs go to 0 asynchronously. After release, nothing is valid until a new phase_valid.
- A new pinc/poff load does not flush the pipeline. Samples already in flight keep their old phase.

## Structure
- Package duc_pkg holds LATENCY, SHIFT, A, LUT init function, and the quadrant-fold helper.
- Sub-module nco_sincos contains pipeline stages 2–4: phase in, registered cos/sin out, with 3-cycle latency. The LUT is a single-port ROM read twice per cycle, or duplicated.

## Test plan
- **Reset:** hold rst_n=0 with random inputs → dac_out=0, valid_out=0, underrun_cnt=0. Release with no phase_valid → outputs stay 0.
- **DC, phase 0:** phase_valid with pinc=0, poff=0, resync=1; then I=16384, Q=0 continuous → valid_out rises 7 cycles after phase_valid; dac_out=4096, which exercises the exact half-up rounding case.
- **Quarter-turn tone:** pinc=2^30, poff=0, resync=1; I=16384, Q=0 → dac_out cycles 4096, 0, −4095, 0.
- **Saturation:** pinc=0, poff=2^29 (45°); I=32767, Q=−32768 → raw value 11584 clamps to dac_out=8191. With I=−32768, Q=32767 → dac_out=−8192.
- **Underrun and resync:** after configuration, drop valid_in for 5 cycles → underrun_cnt=5, and dac_out=0 for exactly those samples 6 cycles later. Then phase_valid&resync → underrun_cnt=0 and acc restarts at 0.
- **Mid-stream reset:** assert rst_n=0 during a running tone → dac_out and valid_out go to 0 without waiting for a clock edge.
